// File: rtl/qr_array_sched.sv
// Issue scheduler for the systolic Givens-rotation QR array: buffers A row-major,
// then feeds the column inputs with diagonal skew, flush rows, a drain wait and a done pulse.
module qr_array_sched #(
    parameter int DATA_WIDTH   = 20,
    parameter int ROWS         = 4,
    parameter int COLS         = 3,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       stall,
    output logic [COLS-1:0]            arr_valid,
    output logic [COLS*DATA_WIDTH-1:0] arr_aij,
    output logic [COLS-1:0]            arr_propagate,
    output logic                       busy,
    output logic                       done
);

    localparam int T   = ROWS + COLS;
    localparam int L   = T + COLS - 1;
    localparam int N   = ROWS * COLS;
    localparam int KW  = $clog2(N);
    localparam int SW  = $clog2(L);
    localparam int DCW = $clog2(DRAIN_CYCLES);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    r_state;
    logic [KW-1:0]             r_k;
    logic [RW-1:0]             r_wrow;
    logic [CW-1:0]             r_wcol;
    logic [SW-1:0]             r_s;
    logic [DCW-1:0]            r_d;
    logic [DATA_WIDTH-1:0]     r_buf [ROWS][COLS];
    logic [COLS-1:0]           r_arr_valid;
    logic [COLS-1:0]           r_arr_prop;
    logic [COLS*DATA_WIDTH-1:0] r_arr_aij;
    logic                      r_busy;
    logic                      r_done;

    logic [COLS-1:0]           w_slot_valid;
    logic [COLS-1:0]           w_slot_prop;
    logic [COLS*DATA_WIDTH-1:0] w_slot_aij;
    logic                      w_accept;

    assign in_ready      = rst_n && (r_state == S_LOAD);
    assign w_accept      = in_valid && in_ready;
    assign arr_valid     = r_arr_valid;
    assign arr_propagate = r_arr_prop;
    assign arr_aij       = r_arr_aij;
    assign busy          = r_busy;
    assign done          = r_done;

    // Column j sees data row r = s - j; rows ROWS..T-1 are the zero/propagate flush rows.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [SW:0]   w_s_ext;
        logic [RW-1:0] w_row;
        logic          w_lo;
        logic          w_in_data;
        logic          w_in_flush;

        assign w_s_ext = {1'b0, r_s};
        if (j == 0) begin : g_first
            assign w_lo = 1'b1;
        end else begin : g_other
            assign w_lo = (w_s_ext >= (SW+1)'(j));
        end
        assign w_in_data  = w_lo && (w_s_ext < (SW+1)'(j + ROWS));
        assign w_in_flush = (w_s_ext >= (SW+1)'(j + ROWS)) && (w_s_ext < (SW+1)'(j + T));
        assign w_row      = RW'(r_s - SW'(j));

        assign w_slot_valid[j] = w_in_data || w_in_flush;
        assign w_slot_prop[j]  = w_in_flush;
        assign w_slot_aij[j*DATA_WIDTH +: DATA_WIDTH] =
            w_in_data ? r_buf[w_row][j] : '0;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wrow][r_wcol] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_k         <= '0;
            r_wrow      <= '0;
            r_wcol      <= '0;
            r_s         <= '0;
            r_d         <= '0;
            r_arr_valid <= '0;
            r_arr_prop  <= '0;
            r_arr_aij   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_arr_valid <= '0;
            r_arr_prop  <= '0;
            r_arr_aij   <= '0;
            r_done      <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_k == KW'(N - 1)) begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                            r_k     <= '0;
                            r_wrow  <= '0;
                            r_wcol  <= '0;
                            r_s     <= '0;
                        end else begin
                            r_k <= r_k + 1'b1;
                            if (r_wcol == CW'(COLS - 1)) begin
                                r_wcol <= '0;
                                r_wrow <= r_wrow + 1'b1;
                            end else begin
                                r_wcol <= r_wcol + 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_arr_valid <= w_slot_valid;
                        r_arr_prop  <= w_slot_prop;
                        r_arr_aij   <= w_slot_aij;
                        if (r_s == SW'(L - 1)) begin
                            r_state <= S_DRAIN;
                            r_s     <= '0;
                            r_d     <= '0;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (r_d == DCW'(DRAIN_CYCLES - 1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_d     <= '0;
                        end else begin
                            r_d <= r_d + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
